// File: rtl/stack_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : stack_arbiter
// Description : Round-robin arbiter serialising two requesters onto one stack.
// Revision    : 1.0
// ============================================================================
module stack_arbiter #(
  parameter int IO_WIDTH = 8,
  parameter int POP_LAT  = 2
) (
  input  logic                clk,
  input  logic                _rst_n,
  input  logic                req0,
  input  logic                req1,
  input  logic                op0,
  input  logic                op1,
  input  logic [IO_WIDTH-1:0] wdata0,
  input  logic [IO_WIDTH-1:0] wdata1,
  output logic                ack0,
  output logic                ack1,
  output logic                err0,
  output logic                err1,
  output logic [IO_WIDTH-1:0] rdata0,
  output logic [IO_WIDTH-1:0] rdata1,
  output logic                st_push,
  output logic                st_pop,
  output logic [IO_WIDTH-1:0] st_din,
  input  logic [IO_WIDTH-1:0] st_dout,
  input  logic                st_full,
  input  logic                st_empty,
  output logic                busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] c_cnt_init = 2'(POP_LAT - 1);

  state_t              r_state;
  logic                r_win;
  logic                r_op;
  logic                r_last;
  logic                r_busy;
  logic [1:0]          r_cnt;
  logic [IO_WIDTH-1:0] r_wdata;
  logic                r_ack0;
  logic                r_ack1;
  logic                r_err0;
  logic                r_err1;
  logic [IO_WIDTH-1:0] r_rdata0;
  logic [IO_WIDTH-1:0] r_rdata1;
  logic                r_push;
  logic                r_pop;

  logic                w_win;
  logic                w_refuse;

  // On a tie the requester that was not served last wins.
  assign w_win    = (req0 && req1) ? ~r_last : req1;
  assign w_refuse = r_op ? st_empty : st_full;

  always_ff @(posedge clk or negedge _rst_n) begin
    if (!_rst_n) begin
      r_state  <= S_IDLE;
      r_win    <= 1'b0;
      r_op     <= 1'b0;
      r_last   <= 1'b1;
      r_busy   <= 1'b0;
      r_cnt    <= 2'd0;
      r_wdata  <= '0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_push   <= 1'b0;
      r_pop    <= 1'b0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      r_err0 <= 1'b0;
      r_err1 <= 1'b0;
      r_push <= 1'b0;
      r_pop  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req0 || req1) begin
            r_win   <= w_win;
            r_op    <= w_win ? op1 : op0;
            r_wdata <= w_win ? wdata1 : wdata0;
            r_busy  <= 1'b1;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (w_refuse) begin
            r_ack0  <= ~r_win;
            r_ack1  <= r_win;
            r_err0  <= ~r_win;
            r_err1  <= r_win;
            r_state <= S_DONE;
          end else begin
            r_push  <= ~r_op;
            r_pop   <= r_op;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_op) begin
            r_cnt   <= c_cnt_init;
            r_state <= S_WAIT;
          end else begin
            r_ack0  <= ~r_win;
            r_ack1  <= r_win;
            r_state <= S_DONE;
          end
        end
        S_WAIT: begin
          if (r_cnt == 2'd0) begin
            if (r_win) r_rdata1 <= st_dout;
            else       r_rdata0 <= st_dout;
            r_ack0  <= ~r_win;
            r_ack1  <= r_win;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        S_DONE: begin
          r_last  <= r_win;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ack0    = r_ack0;
  assign ack1    = r_ack1;
  assign err0    = r_err0;
  assign err1    = r_err1;
  assign rdata0  = r_rdata0;
  assign rdata1  = r_rdata1;
  assign st_push = r_push;
  assign st_pop  = r_pop;
  assign st_din  = r_wdata;
  assign busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_stack_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_stack_arbiter
// Description : Stack responder, transaction-level reference model, directed
//               scenarios and randomized traffic for stack_arbiter.
// Revision    : 1.0
// ============================================================================
module tb_stack_arbiter;
  localparam int W     = 8;
  localparam int PL    = 2;
  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0, op0 = 1'b0, op1 = 1'b0;
  logic [W-1:0] wdata0 = '0, wdata1 = '0;
  logic         ack0, ack1, err0, err1, st_push, st_pop, busy;
  logic [W-1:0] rdata0, rdata1, st_din, st_dout;
  logic         st_full, st_empty;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stack_arbiter #(.IO_WIDTH(W), .POP_LAT(PL)) dut (
    .clk(clk), ._rst_n(rst_n),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .st_push(st_push), .st_pop(st_pop), .st_din(st_din),
    .st_dout(st_dout), .st_full(st_full), .st_empty(st_empty),
    .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stack controller: popped data shows up PL cycles after the strobe cycle,
  // random garbage otherwise, so a mistimed capture is visible.
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] pipe [PL+1];
  int cnt = 0;
  int n_push = 0;
  int n_pop = 0;
  assign st_full  = (cnt == DEPTH);
  assign st_empty = (cnt == 0);
  assign st_dout  = pipe[PL];

  always @(negedge clk) begin
    for (int k = PL; k > 0; k--) pipe[k] = pipe[k-1];
    pipe[0] = W'($urandom);
    if (st_push && cnt < DEPTH) begin mem[cnt] = st_din; cnt++; end
    if (st_pop && cnt > 0) begin cnt--; pipe[0] = mem[cnt]; end
    n_push += int'(st_push);
    n_pop  += int'(st_pop);
  end

  // Reference model: a latched operation occupies a fixed number of cycles
  // (2 refused, 3 push, 3+PL pop); strobe in its 2nd cycle, ack in its last.
  bit           mbusy = 0, mw = 0, mop = 0, mref = 0, mlast = 1;
  int           t = 0, L = 0;
  logic [W-1:0] mdata = '0, mpopv = '0, exp_din = '0;
  logic [W-1:0] exp_rd [2] = '{default: '0};
  logic [W-1:0] mq [$];

  always @(negedge clk) begin : model
    bit e_push, e_pop, e_ack, e_err;
    if (!rst_n) begin
      chk("rst_busy", busy, 0);   chk("rst_ack0", ack0, 0);  chk("rst_ack1", ack1, 0);
      chk("rst_err0", err0, 0);   chk("rst_err1", err1, 0);
      chk("rst_rdata0", rdata0, 0); chk("rst_rdata1", rdata1, 0);
      chk("rst_push", st_push, 0); chk("rst_pop", st_pop, 0); chk("rst_din", st_din, 0);
      mbusy = 0; mlast = 1; exp_din = '0; exp_rd[0] = '0; exp_rd[1] = '0;
    end else begin
      if (mbusy && t == 0) begin
        mref = mop ? (mq.size() == 0) : (mq.size() == DEPTH);
        L    = mref ? 2 : (mop ? 3 + PL : 3);
      end
      e_push = mbusy && t == 1 && !mref && !mop;
      e_pop  = mbusy && t == 1 && !mref && mop;
      e_ack  = mbusy && t == L - 1;
      e_err  = e_ack && mref;
      if (e_push) mq.push_back(mdata);
      if (e_pop)  mpopv = mq.pop_back();
      if (e_ack && mop && !mref) exp_rd[mw] = mpopv;
      chk("busy", busy, mbusy);
      chk("st_push", st_push, e_push);
      chk("st_pop", st_pop, e_pop);
      chk("st_din", st_din, exp_din);
      chk("ack0", ack0, e_ack && !mw);
      chk("ack1", ack1, e_ack && mw);
      chk("err0", err0, e_err && !mw);
      chk("err1", err1, e_err && mw);
      chk("rdata0", rdata0, exp_rd[0]);
      chk("rdata1", rdata1, exp_rd[1]);
      if (mbusy) begin
        t++;
        if (t == L) begin mbusy = 0; mlast = mw; end
      end else if (req0 || req1) begin
        mw      = (req0 && req1) ? ~mlast : req1;
        mop     = mw ? op1 : op0;
        mdata   = mw ? wdata1 : wdata0;
        exp_din = mdata;
        mbusy   = 1; t = 0;
      end
    end
  end

  task automatic do_op(input bit who, input bit op, input logic [W-1:0] d,
                       input int exp_lat, input bit exp_err, input string tag);
    int n; bit got, e;
    if (who) begin req1 = 1; op1 = op; wdata1 = d; end
    else     begin req0 = 1; op0 = op; wdata0 = d; end
    n = 0; got = 0; e = 0;
    while (!got && n < 60) begin
      @(negedge clk); n++;
      got = who ? ack1 : ack0;
      e   = who ? err1 : err0;
    end
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_err"}, e, exp_err);
    @(posedge clk); #1;
    if (who) req1 = 0; else req0 = 0;
  endtask

  task automatic drive_req(input bit who, input bit acked, input int bias);
    bit r;
    r = who ? req1 : req0;
    if (!r || acked) begin
      r = ($urandom_range(99) < 60);
      if (r) begin
        if (who) begin op1 = ($urandom_range(99) >= bias); wdata1 = W'($urandom); end
        else     begin op0 = ($urandom_range(99) >= bias); wdata0 = W'($urandom); end
      end
    end else if ($urandom_range(99) == 0) begin
      r = 0;
    end
    if (who) req1 = r; else req0 = r;
  endtask

  initial begin : main
    int p, nack, na, cyc, bias;
    int ord [8];
    int at [8];
    bit a0, a1, seen;
    for (int k = 0; k <= PL; k++) pipe[k] = '0;
    repeat (3) @(posedge clk);
    #1 chk("reset_busy_lit", busy, 0);
    rst_n = 1;

    // push then pop on the same requester
    p = n_push;
    do_op(0, 0, 8'hA5, 4, 0, "push_a5");
    chk("push_a5_strobes", n_push - p, 1);
    do_op(0, 1, 8'h00, 4 + PL, 0, "pop_a5");
    chk("pop_a5_data", rdata0, 8'hA5);

    // underflow
    p = n_pop;
    do_op(0, 1, 8'h00, 3, 1, "udf");
    chk("udf_nopop", n_pop - p, 0);
    chk("udf_rdata_kept", rdata0, 8'hA5);

    // fresh pointer, then simultaneous pushes
    rst_n = 0; @(posedge clk); #1; rst_n = 1;
    req0 = 1; op0 = 0; wdata0 = 8'h11;
    req1 = 1; op1 = 0; wdata1 = 8'h22;
    p = n_push; nack = 0;
    for (int c = 0; c < 60 && nack < 2; c++) begin
      @(negedge clk); a0 = ack0; a1 = ack1;
      if (a0) begin ord[nack] = 0; at[nack] = c; nack++; end
      if (a1) begin ord[nack] = 1; at[nack] = c; nack++; end
      @(posedge clk); #1;
      if (a0) req0 = 0;
      if (a1) req1 = 0;
    end
    chk("tie_acks", nack, 2);
    chk("tie_first", ord[0], 0);
    chk("tie_second", ord[1], 1);
    chk("tie_gap", at[1] - at[0], 4);
    chk("tie_strobes", n_push - p, 2);

    // both held continuously: acks alternate
    req0 = 1; op0 = 0; wdata0 = 8'h33;
    req1 = 1; op1 = 1;
    nack = 0;
    for (int c = 0; c < 200 && nack < 8; c++) begin
      @(negedge clk);
      if (ack0 && nack < 8) begin ord[nack] = 0; nack++; end
      if (ack1 && nack < 8) begin ord[nack] = 1; nack++; end
      @(posedge clk); #1;
    end
    req0 = 0; req1 = 0;
    chk("fair_acks", nack, 8);
    for (int k = 0; k < 8; k++) chk($sformatf("fair_order%0d", k), ord[k], k % 2);

    // drain, fill, overflow, LIFO order
    for (int k = 0; k < 12 && !st_empty; k++) do_op(1, 1, 8'h00, 4 + PL, 0, "drain");
    for (int k = 0; k < 8; k++) do_op(0, 0, W'(8'h40 + k), 4, 0, "fill");
    chk("fill_full", st_full, 1);
    p = n_push;
    do_op(0, 0, 8'hEE, 3, 1, "ovf");
    chk("ovf_nopush", n_push - p, 0);
    do_op(1, 1, 8'h00, 4 + PL, 0, "lifo");
    chk("lifo_data", rdata1, 8'h47);

    // reset during the pop wait
    req1 = 1; op1 = 1; seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin @(negedge clk); seen = st_pop; end
    chk("rstpop_seen", seen, 1);
    @(posedge clk); #1;
    rst_n = 0; req1 = 0;
    #1 chk("rstpop_busy", busy, 0);
    na = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); na += int'(ack0 | ack1);
      @(posedge clk); #1;
      if (c == 1) rst_n = 1;
    end
    chk("rstpop_noack", na, 0);
    do_op(0, 0, 8'h5A, 4, 0, "post_rst");

    // randomized traffic, push-heavy and pop-heavy windows
    cyc = 0;
    while (cyc < 3000) begin
      @(negedge clk); a0 = ack0; a1 = ack1;
      @(posedge clk); #1;
      cyc++;
      bias = ((cyc / 250) % 2 == 1) ? 25 : 75;
      if ($urandom_range(999) == 0) begin
        rst_n = 0; req0 = 0; req1 = 0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1;
      end else begin
        drive_req(0, a0, bias);
        drive_req(1, a1, bias);
      end
    end
    req0 = 0; req1 = 0;
    repeat (10) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
